// File: rtl/sign_ext_pkg.sv
// rtl/sign_ext_pkg.sv - shared opcodes, format enum and immediate field positions
//
// Purpose: constants and types shared by the sign-extension decode and
//          register stages.
// Contents:
//   OP_LDUR, OP_STUR : 11-bit D-format opcodes (instruction bits [31:21])
//   OP_CBZ           : 8-bit CB-format opcode (instruction bits [31:24])
//   fmt_t            : decoded instruction format
//   IMM9_*, IMM19_*  : immediate field positions inside the instruction word
package sign_ext_pkg;

    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [7:0]  OP_CBZ  = 8'hB4;

    // Code 3 is reserved and never produced.
    typedef enum logic [1:0] {
        FMT_NONE = 2'd0,
        FMT_D    = 2'd1,
        FMT_CB   = 2'd2
    } fmt_t;

    localparam int D_OP_LSB  = 21;
    localparam int CB_OP_LSB = 24;

    localparam int IMM9_LSB  = 12;
    localparam int IMM9_W    = 9;
    localparam int IMM19_LSB = 5;
    localparam int IMM19_W   = 19;

endpackage

// File: rtl/sign_ext_if.sv
// rtl/sign_ext_if.sv - instruction-in / immediate-out bundle for sign_ext
//
// Purpose: groups the valid-qualified instruction input and the registered
//          immediate result.
// Signals:
//   in_valid  : a carries an instruction to convert this cycle
//   a         : 32-bit instruction word
//   out_valid : y/fmt hold a freshly converted result
//   y         : sign-extended immediate, Y_W bits
//   fmt       : decoded format (0 NONE, 1 D, 2 CB)
// Modports:
//   master : instruction source / result consumer
//   slave  : the sign-extension unit
interface sign_ext_if #(
    parameter int Y_W = 64
);

    logic           in_valid;
    logic [31:0]    a;
    logic           out_valid;
    logic [Y_W-1:0] y;
    logic [1:0]     fmt;

    modport master (
        output in_valid,
        output a,
        input  out_valid,
        input  y,
        input  fmt
    );

    modport slave (
        input  in_valid,
        input  a,
        output out_valid,
        output y,
        output fmt
    );

endinterface

// File: rtl/sign_ext_decode.sv
// rtl/sign_ext_decode.sv - combinational opcode decode and immediate sign extension
//
// Purpose: recognises LDUR/STUR (D format) and CBZ (CB format), extracts the
//          immediate and sign-extends it to Y_W bits. Anything else yields
//          FMT_NONE and a zero immediate.
// Ports:
//   a      : in,  32-bit instruction word
//   y_next : out, sign-extended immediate
//   fmt    : out, decoded format
module sign_ext_decode
    import sign_ext_pkg::*;
#(
    parameter int Y_W = 64
) (
    input  logic [31:0]    a,
    output logic [Y_W-1:0] y_next,
    output fmt_t           fmt
);

    logic [IMM9_W-1:0]  imm9;
    logic [IMM19_W-1:0] imm19;
    logic [10:0]        d_op;
    logic [7:0]         cb_op;

    // Register fields a[4:0] carry no immediate bits.
    logic unused_reg_bits;
    assign unused_reg_bits = ^a[IMM19_LSB-1:0];

    assign imm9  = a[IMM9_LSB  +: IMM9_W];
    assign imm19 = a[IMM19_LSB +: IMM19_W];
    assign d_op  = a[D_OP_LSB  +: 11];
    assign cb_op = a[CB_OP_LSB +: 8];

    // D is checked first; the opcode patterns are disjoint, so the order
    // only matters as a tie-break guarantee.
    always_comb begin
        y_next = '0;
        fmt    = FMT_NONE;
        if (d_op == OP_LDUR || d_op == OP_STUR) begin
            y_next = {{(Y_W-IMM9_W){imm9[IMM9_W-1]}}, imm9};
            fmt    = FMT_D;
        end else if (cb_op == OP_CBZ) begin
            y_next = {{(Y_W-IMM19_W){imm19[IMM19_W-1]}}, imm19};
            fmt    = FMT_CB;
        end
    end

endmodule

// File: rtl/sign_ext.sv
// rtl/sign_ext.sv - registered sign-extension unit for the decode stage
//
// Purpose: one-cycle-latency conversion of an instruction word into its
//          sign-extended immediate and decoded format. No backpressure: a new
//          instruction may be accepted every cycle.
// Ports:
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : sign_ext_if.slave (in_valid, a -> out_valid, y, fmt)
module sign_ext
    import sign_ext_pkg::*;
#(
    parameter int Y_W = 64
) (
    input  logic       clk,
    input  logic       reset,
    sign_ext_if.slave  bus
);

    logic [Y_W-1:0] y_next;
    fmt_t           fmt_next;

    sign_ext_decode #(
        .Y_W (Y_W)
    ) u_decode (
        .a      (bus.a),
        .y_next (y_next),
        .fmt    (fmt_next)
    );

    // y/fmt hold across idle cycles; only out_valid drops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.y         <= '0;
            bus.fmt       <= FMT_NONE;
            bus.out_valid <= 1'b0;
        end else if (bus.in_valid) begin
            bus.y         <= y_next;
            bus.fmt       <= fmt_next;
            bus.out_valid <= 1'b1;
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sign_ext.sv
// tb/tb_sign_ext.sv - directed self-checking bench for sign_ext
module tb_sign_ext;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sign_ext_if #(.Y_W(64)) bus ();

    sign_ext #(.Y_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] vec_a   [10];
    logic [63:0] vec_y   [10];
    logic [1:0]  vec_fmt [10];

    task automatic chk(input string tag, input logic [63:0] y_exp,
                       input logic [1:0] fmt_exp, input logic ov_exp);
        checks++;
        assert (bus.y === y_exp) else begin
            errors++;
            $error("FAIL %s y observed=%h expected=%h", tag, bus.y, y_exp);
        end
        checks++;
        assert (bus.fmt === fmt_exp) else begin
            errors++;
            $error("FAIL %s fmt observed=%0d expected=%0d", tag, bus.fmt, fmt_exp);
        end
        checks++;
        assert (bus.out_valid === ov_exp) else begin
            errors++;
            $error("FAIL %s out_valid observed=%b expected=%b", tag, bus.out_valid, ov_exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] instr);
        bus.in_valid = v;
        bus.a        = instr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        vec_a[0] = 32'hF8401022; vec_y[0] = 64'h0000000000000001; vec_fmt[0] = 2'd1;
        vec_a[1] = 32'hF85FF000; vec_y[1] = 64'hFFFFFFFFFFFFFFFF; vec_fmt[1] = 2'd1;
        vec_a[2] = 32'hF8002000; vec_y[2] = 64'h0000000000000002; vec_fmt[2] = 2'd1;
        vec_a[3] = 32'hF81FE000; vec_y[3] = 64'hFFFFFFFFFFFFFFFE; vec_fmt[3] = 2'd1;
        vec_a[4] = 32'hB4000060; vec_y[4] = 64'h0000000000000003; vec_fmt[4] = 2'd2;
        vec_a[5] = 32'hB4FFFFA0; vec_y[5] = 64'hFFFFFFFFFFFFFFFD; vec_fmt[5] = 2'd2;
        vec_a[6] = 32'hF84FF000; vec_y[6] = 64'h00000000000000FF; vec_fmt[6] = 2'd1;
        vec_a[7] = 32'hB4800000; vec_y[7] = 64'hFFFFFFFFFFFC0000; vec_fmt[7] = 2'd2;
        vec_a[8] = 32'hC0C4C014; vec_y[8] = 64'h0000000000000000; vec_fmt[8] = 2'd0;
        vec_a[9] = 32'hFFFFFFFF; vec_y[9] = 64'h0000000000000000; vec_fmt[9] = 2'd0;

        // Reset held two cycles with in_valid asserted.
        reset = 1'b0;
        cyc(1'b1, 32'hF84013E2);
        chk("reset_c1", 64'h0, 2'd0, 1'b0);
        cyc(1'b1, 32'hF84013E2);
        chk("reset_c2", 64'h0, 2'd0, 1'b0);

        // Release: the held instruction converts on the next edge.
        reset = 1'b1;
        cyc(1'b1, 32'hF84013E2);
        chk("post_reset", 64'h1, 2'd1, 1'b1);

        // Idle cycle: out_valid drops, y/fmt hold.
        cyc(1'b0, 32'hB4000060);
        chk("idle_hold", 64'h1, 2'd1, 1'b0);

        // Latency: presenting a new vector must not change outputs before the edge.
        bus.in_valid = 1'b1;
        bus.a        = 32'hF85FF000;
        #1;
        chk("pre_edge", 64'h1, 2'd1, 1'b0);
        @(posedge clk);
        #1;
        chk("ldur_neg_lat1", 64'hFFFFFFFFFFFFFFFF, 2'd1, 1'b1);

        // Back-to-back stream of all vectors.
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, vec_a[i]);
            chk($sformatf("stream_%0d", i), vec_y[i], vec_fmt[i], 1'b1);
        end

        // Drop in_valid: y holds last (zero) value.
        cyc(1'b0, 32'hF8401022);
        chk("stream_idle", 64'h0, 2'd0, 1'b0);

        // Reset mid-stream.
        cyc(1'b1, vec_a[1]);
        chk("mid_pre", 64'hFFFFFFFFFFFFFFFF, 2'd1, 1'b1);
        reset = 1'b0;
        cyc(1'b1, vec_a[5]);
        chk("mid_reset", 64'h0, 2'd0, 1'b0);
        reset = 1'b1;
        cyc(1'b1, vec_a[5]);
        chk("mid_resume", 64'hFFFFFFFFFFFFFFFD, 2'd2, 1'b1);
        cyc(1'b0, 32'h0);
        chk("final_idle", 64'hFFFFFFFFFFFFFFFD, 2'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sign_ext.md
Name: sign_ext

Overview:
- Registered sign-extension unit for the single-cycle/pipelined ARMv8 (LEGv8 subset) datapath. It sits in the decode stage, between the instruction memory and the ALU B-mux / branch-target adder.
- Decodes the opcode of a 32-bit instruction, extracts the immediate field, and sign-extends it to 64 bits.
- Instructions it does not recognise produce zero.

Parameters:
- Y_W, 64, output width; the immediate is sign-extended to this width. Only 64 is required to be supported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-low reset; sampled on rising clk
- in_valid  input  1  a carries an instruction to convert this cycle
- a  input  32  instruction word
- out_valid  output  1  y/fmt hold a freshly converted result
- y  output  Y_W  sign-extended immediate, registered
- fmt  output  2  decoded format, registered: 0 = NONE, 1 = D (LDUR/STUR), 2 = CB (CBZ), 3 = reserved (never produced)

Behaviour:
Reset
- At a rising clk edge with reset==0: y = 0, fmt = 0, out_valid = 0.
- Reset overrides in_valid in the same cycle.
- Any conversion in flight is discarded.

Latency and handshake
- Latency is exactly 1 cycle. At a rising edge with reset==1 and in_valid==1, the conversion of a is captured into y and fmt, and out_valid is set to 1.
- At a rising edge with reset==1 and in_valid==0: out_valid is set to 0; y and fmt hold their previous values.
- There is no backpressure. A new input can be accepted every cycle, so back-to-back in_valid gives back-to-back out_valid.

Decode (combinational, on a)
- LDUR: a[31:21] == 11'b111_1100_0010 -> fmt D, imm = a[20:12] (9 bits).
- STUR: a[31:21] == 11'b111_1100_0000 -> fmt D, imm = a[20:12].
- CBZ: a[31:24] == 8'b1011_0100 -> fmt CB, imm = a[23:5] (19 bits).
- Anything else -> fmt NONE, y = 0.

Extension and width rules
- y = {(Y_W - width(imm)){imm[msb]}, imm}, i.e. a pure sign extension.
- No scaling, shifting or offset is applied.
- The D and CB opcode patterns cannot both match; the D check has priority anyway.

Boundary conditions
- imm9 = 0x1FF -> y = 0xFFFF_FFFF_FFFF_FFFF.
- imm9 = 0x0FF -> y = 0x0000_0000_0000_00FF.
- imm19 = 0x40000 -> y = 0xFFFF_FFFF_FFFC_0000.
- All-ones instruction 0xFFFFFFFF -> NONE, y = 0.
- Outputs never carry X after the first reset.

Decomposition:
- Shared package sign_ext_pkg contains:
  - opcode constants OP_LDUR = 11'h7C2, OP_STUR = 11'h7C0, OP_CBZ = 8'hB4;
  - enum fmt_t {FMT_NONE, FMT_D, FMT_CB};
  - field-position localparams for imm9 and imm19.
- One combinational sub-module, sign_ext_decode, takes a and returns the next y and fmt. The top level holds only the output registers and the valid logic.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 and a=0xF84013E2 -> y=0, fmt=0, out_valid=0. Release reset and keep in_valid=1 -> one cycle later y=1, fmt=D, out_valid=1.
- LDUR positive and negative:
  - a=0b111_1100_0010_000000001_00_00001_00010 -> y=0x0000000000000001, fmt=D.
  - imm9 = 111111111 -> y=0xFFFFFFFFFFFFFFFF.
  - Result appears exactly 1 cycle after the in_valid edge.
- STUR: imm9 = 000000010 -> y=2; imm9 = 111111110 -> y=0xFFFFFFFFFFFFFFFE. Both fmt=D.
- CBZ: a[31:24]=0xB4 with imm19=3 -> y=3, fmt=CB; imm19=0x7FFFD -> y=0xFFFFFFFFFFFFFFFD.
- Unrecognised: a=0xC0C4C014 -> y=0, fmt=NONE; a=0xFFFFFFFF -> y=0, fmt=NONE. Both with out_valid=1.
- Handshake:
  - Stream the 8 vectors above back-to-back -> 8 consecutive out_valid cycles with the matching results.
  - Then drop in_valid for 1 cycle -> out_valid=0, y holds the last value (0).
  - Assert reset mid-stream -> the next cycle has y=0, out_valid=0.
